// File: rtl/wash_pkg.sv
// wash_pkg: shared state encoding, blank digit code and status lamp indices
package wash_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WASH, S_RINSE, S_SPIN, S_DONE} state_t;
  localparam logic [3:0] BLANK = 4'd11;
  localparam int L_IDLE = 0;
  localparam int L_WASH = 1;
  localparam int L_RINSE = 2;
  localparam int L_SPIN = 3;
  localparam int L_DONE = 4;
  localparam int L_INSUF = 5;
  localparam int L_PAUSE = 6;
  localparam int L_TICK = 7;
endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: combinational double-dabble with saturation to all 9s and leading-zero blanking
module bin2bcd
  import wash_pkg::*;
#(
  parameter int IN_W = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic [IN_W-1:0]         bin,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  localparam int MAXV = 10 ** NUM_DIGITS - 1;
  logic [4*NUM_DIGITS-1:0] acc;
  logic [3:0] d;
  logic sat, lead;
  always_comb begin
    acc = '0;
    d = '0;
    bcd = '0;
    lead = 1'b1;
    sat = 64'(bin) > 64'(MAXV);
    for (int i = IN_W - 1; i >= 0; i--) begin
      for (int j = 0; j < NUM_DIGITS; j++)
        acc[4*j+:4] = (acc[4*j+:4] >= 4'd5) ? acc[4*j+:4] + 4'd3 : acc[4*j+:4];
      acc = {acc[4*NUM_DIGITS-2:0], bin[i]};
    end
    // Blank from the top down until the first non-zero digit; digit 0 always shows
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      d = sat ? 4'd9 : acc[4*j+:4];
      lead = lead && (d == 4'd0) && (j != 0);
      bcd[4*j+:4] = lead ? BLANK : d;
    end
  end
endmodule

// File: rtl/wash_billing_timer.sv
// wash_billing_timer: pay-per-second washer sequencer with balance pre-check,
// per-phase pricing, pause and a registered BCD display of time or balance
module wash_billing_timer
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int BAL_W = 10,
  parameter int NUM_DIGITS = 4,
  parameter int T_WASH = 30,
  parameter int T_RINSE = 20,
  parameter int T_SPIN = 10,
  parameter int P_WASH = 1,
  parameter int P_RINSE = 1,
  parameter int P_SPIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    on,
  input  logic                    start,
  input  logic                    bal_load,
  input  logic [BAL_W-1:0]        bal_in,
  input  logic                    disp_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [7:0]              st_light,
  output logic                    done
);
  localparam int unsigned COST = T_WASH * P_WASH + T_RINSE * P_RINSE + T_SPIN * P_SPIN;
  localparam int T_TOT = T_WASH + T_RINSE + T_SPIN;
  localparam int TW = $clog2(T_TOT + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int VW = (BAL_W > TW) ? BAL_W : TW;
  localparam logic [4*NUM_DIGITS-1:0] DIG_RST = {{(NUM_DIGITS - 1){BLANK}}, 4'd0};

  state_t state_q, state_d, succ;
  logic [BAL_W-1:0] bal_q, bal_d, price;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] ph_q, ph_d, tot_q, tot_d;
  logic insuf_q, insuf_d, tog_q, tog_d, run, tick;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;

  // Zero-length phases fall through to the next one in the same edge
  function automatic state_t skip(input state_t s);
    state_t r;
    r = s;
    if (r == S_WASH && T_WASH == 0) r = S_RINSE;
    if (r == S_RINSE && T_RINSE == 0) r = S_SPIN;
    if (r == S_SPIN && T_SPIN == 0) r = S_DONE;
    return r;
  endfunction

  function automatic logic [TW-1:0] dur(input state_t s);
    return (s == S_WASH) ? TW'(T_WASH) : (s == S_RINSE) ? TW'(T_RINSE) :
           (s == S_SPIN) ? TW'(T_SPIN) : '0;
  endfunction

  always_comb begin
    run = state_q inside {S_WASH, S_RINSE, S_SPIN};
    tick = run && on && (cnt_q == CW'(TICK_DIV - 1));
    price = (state_q == S_WASH) ? BAL_W'(P_WASH) : (state_q == S_RINSE) ? BAL_W'(P_RINSE) : BAL_W'(P_SPIN);
    succ = (state_q == S_WASH) ? S_RINSE : (state_q == S_RINSE) ? S_SPIN : S_DONE;
    state_d = state_q;
    bal_d = bal_q;
    cnt_d = (run && on) ? (tick ? '0 : cnt_q + CW'(1)) : cnt_q;
    ph_d = ph_q;
    tot_d = tot_q;
    insuf_d = insuf_q;
    tog_d = tog_q ^ tick;
    if (state_q == S_IDLE) begin
      if (bal_load) begin
        bal_d = bal_in;
        insuf_d = 1'b0;
      end else if (start && 32'(bal_q) >= COST) begin
        state_d = skip(S_WASH);
        ph_d = dur(state_d);
        tot_d = TW'(T_TOT);
        cnt_d = '0;
      end else if (start) begin
        insuf_d = 1'b1;
      end
    end else if (state_q == S_DONE) begin
      if (start) state_d = S_IDLE;
    end else if (tick) begin
      bal_d = (bal_q >= price) ? bal_q - price : '0;
      tot_d = tot_q - TW'(1);
      ph_d = ph_q - TW'(1);
      if (ph_q == TW'(1)) begin
        state_d = skip(succ);
        ph_d = dur(state_d);
      end
    end
    st_light = '0;
    st_light[L_IDLE] = state_q == S_IDLE;
    st_light[L_WASH] = state_q == S_WASH;
    st_light[L_RINSE] = state_q == S_RINSE;
    st_light[L_SPIN] = state_q == S_SPIN;
    st_light[L_DONE] = state_q == S_DONE;
    st_light[L_INSUF] = insuf_q;
    st_light[L_PAUSE] = run && !on;
    st_light[L_TICK] = tog_q;
    done = state_q == S_DONE;
    digits = digits_q;
  end

  bin2bcd #(.IN_W(VW), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
    .bin(disp_sel ? VW'(bal_q) : VW'(tot_q)),
    .bcd(digits_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bal_q <= '0;
      cnt_q <= '0;
      ph_q <= '0;
      tot_q <= '0;
      insuf_q <= 1'b0;
      tog_q <= 1'b0;
      digits_q <= DIG_RST;
    end else begin
      state_q <= state_d;
      bal_q <= bal_d;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
      tot_q <= tot_d;
      insuf_q <= insuf_d;
      tog_q <= tog_d;
      digits_q <= digits_d;
    end
  end
endmodule

// File: tb/tb_wash_billing_timer.sv
// tb_wash_billing_timer: directed stimulus with a seconds-based billing model checked every cycle
module tb_wash_billing_timer;
  localparam int TD = 4, TWS = 30, TR = 20, TS = 10, PW = 1, PR = 1, PS = 2;
  localparam int TT = TWS + TR + TS, COST = TWS * PW + TR * PR + TS * PS;

  logic clk = 1'b0, rst, on, start, bal_load, disp_sel;
  logic [9:0] bal_in;
  logic [15:0] digits;
  logic [7:0] st_light;
  logic done;
  logic d2_start, d2_load, d2_disp;
  logic [13:0] d2_bal;
  logic [15:0] d2_digits;
  logic [7:0] d2_light;
  logic d2_done;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  wash_billing_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .on(on), .start(start), .bal_load(bal_load), .bal_in(bal_in),
    .disp_sel(disp_sel), .digits(digits), .st_light(st_light), .done(done)
  );

  wash_billing_timer #(.TICK_DIV(TD), .BAL_W(14), .T_WASH(9999), .T_RINSE(1), .T_SPIN(1)) dut2 (
    .clk(clk), .rst(rst), .on(1'b1), .start(d2_start), .bal_load(d2_load), .bal_in(d2_bal),
    .disp_sel(d2_disp), .digits(d2_digits), .st_light(d2_light), .done(d2_done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_dig(input int v);
    logic [15:0] r;
    int x, d;
    bit lead;
    x = (v > 9999) ? 9999 : v;
    lead = 1'b1;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      d = (x / (10 ** i)) % 10;
      lead = lead && (d == 0) && (i > 0);
      r[4*i+:4] = lead ? 4'hB : 4'(d);
    end
    return r;
  endfunction

  // Money spent after s whole seconds of the programme
  function automatic int charged(input int s);
    int a, b, c;
    a = (s < TWS) ? s : TWS;
    b = (s - TWS < 0) ? 0 : ((s - TWS > TR) ? TR : s - TWS);
    c = (s - TWS - TR < 0) ? 0 : s - TWS - TR;
    return a * PW + b * PR + c * PS;
  endfunction

  int m_mode, m_bal, m_base, m_cyc, m_ticks, m_tog, m_insuf;
  logic [15:0] m_dig;
  logic [7:0] el;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_bal = 0; m_cyc = 0; m_ticks = 0; m_tog = 0; m_insuf = 0;
      m_dig = 16'hBBB0;
    end else begin
      m_dig = to_dig(disp_sel ? m_bal : (m_mode == 1 ? TT - m_ticks : 0));
      if (m_mode == 0) begin
        if (bal_load) begin
          m_bal = int'(bal_in); m_insuf = 0;
        end else if (start && m_bal >= COST) begin
          m_mode = 1; m_base = m_bal; m_cyc = 0; m_ticks = 0;
        end else if (start) m_insuf = 1;
      end else if (m_mode == 1) begin
        if (on) begin
          m_cyc++;
          if (m_cyc % TD == 0) begin
            m_ticks++;
            m_tog ^= 1;
            m_bal = m_base - charged(m_ticks);
            if (m_ticks == TT) m_mode = 2;
          end
        end
      end else if (start) m_mode = 0;
    end
    #1;
    el = '0;
    el[0] = m_mode == 0;
    el[1] = m_mode == 1 && m_ticks < TWS;
    el[2] = m_mode == 1 && m_ticks >= TWS && m_ticks < TWS + TR;
    el[3] = m_mode == 1 && m_ticks >= TWS + TR;
    el[4] = m_mode == 2;
    el[5] = m_insuf != 0;
    el[6] = m_mode == 1 && !on;
    el[7] = m_tog != 0;
    chk("model_light", st_light, el);
    chk("model_done", done, int'(m_mode == 2));
    chk("model_digits", digits, m_dig);
  end

  task automatic load(input int v);
    bal_in = 10'(v); bal_load = 1'b1;
    @(negedge clk);
    bal_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; on = 1'b1; start = 1'b0; bal_load = 1'b0; bal_in = '0; disp_sel = 1'b0;
    d2_start = 1'b0; d2_load = 1'b0; d2_disp = 1'b1; d2_bal = '0;
    repeat (2) @(negedge clk);
    chk("reset_light", st_light, 8'h01);
    chk("reset_digits", digits, 16'hBBB0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    // Full programme
    load(100);
    pulse_start();
    chk("start_light", st_light, 8'h02);
    @(negedge clk);
    chk("start_digits", digits, 16'hBB60);
    wait_done(1, n);
    chk("full_done_edge", n, 240);
    chk("full_done_light", st_light, 8'h10);
    disp_sel = 1'b1;
    @(negedge clk);
    chk("full_balance", digits, 16'hBB30);
    pulse_start();
    chk("done_ack_light", st_light, 8'h01);
    // Insufficient funds, then exactly enough
    load(69);
    pulse_start();
    chk("insuf_light", st_light, 8'h21);
    @(negedge clk);
    chk("insuf_balance", digits, 16'hBB69);
    load(70);
    chk("insuf_cleared", st_light, 8'h01);
    pulse_start();
    chk("exact_start", st_light, 8'h02);
    wait_done(0, n);
    chk("exact_done_edge", n, 240);
    @(negedge clk);
    chk("exact_balance", digits, 16'hBBB0);
    pulse_start();
    // Pause for 10 cycles on RINSE entry
    disp_sel = 1'b0;
    load(100);
    pulse_start();
    n = 0;
    while (!st_light[2] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rinse_entry_edge", n, 120);
    on = 1'b0;
    repeat (10) @(negedge clk);
    n += 10;
    chk("pause_light", st_light, 8'h44);
    chk("pause_digits", digits, 16'hBB30);
    on = 1'b1;
    wait_done(n, n);
    chk("pause_done_edge", n, 250);
    pulse_start();
    // Load and start together: the load wins
    disp_sel = 1'b1;
    bal_in = 10'd42; bal_load = 1'b1; start = 1'b1;
    @(negedge clk);
    bal_load = 1'b0; start = 1'b0;
    chk("load_start_light", st_light, 8'h01);
    @(negedge clk);
    chk("load_start_bal", digits, 16'hBB42);
    // Load ignored while washing, then reset at second 35
    load(80);
    pulse_start();
    load(5);
    @(negedge clk);
    chk("wash_load_ignored", digits, 16'hBB80);
    repeat (138) @(negedge clk);
    chk("pre_reset_rinse", st_light[3:0], 4'h4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_light", st_light, 8'h01);
    chk("mid_reset_digits", digits, 16'hBBB0);
    chk("mid_reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_balance", digits, 16'hBBB0);
    load(5);
    @(negedge clk);
    chk("balance_5", digits, 16'hBBB5);
    // Saturation with an oversized programme
    d2_bal = 14'd1234; d2_load = 1'b1;
    @(negedge clk);
    d2_load = 1'b0;
    @(negedge clk);
    chk("d2_full_width", d2_digits, 16'h1234);
    d2_bal = 14'd12000; d2_load = 1'b1;
    @(negedge clk);
    d2_load = 1'b0;
    @(negedge clk);
    chk("d2_sat_balance", d2_digits, 16'h9999);
    d2_start = 1'b1; d2_disp = 1'b0;
    @(negedge clk);
    d2_start = 1'b0;
    chk("d2_running", d2_light, 8'h02);
    @(negedge clk);
    chk("d2_sat_time", d2_digits, 16'h9999);
    chk("d2_not_done", d2_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wash_billing_timer.md
Name: wash_billing_timer

Overview:
Parametrised pay-per-cycle washing-machine controller. It pre-checks the loaded balance against the programme cost and sequences the WASH, RINSE and SPIN phases from a divided 1 s tick. The price of each phase is deducted per second, and the block emits BCD digit codes for the existing 4-digit scan driver plus an 8-bit status lamp vector. It replaces the fixed single-counter billing block and adds per-phase pricing, pause, insufficient-funds handling and a selectable display source.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s tick (bench uses 4)
BAL_W, 10, balance width in bits
NUM_DIGITS, 4, number of display digits
T_WASH, 30, wash duration in seconds
T_RINSE, 20, rinse duration in seconds
T_SPIN, 10, spin duration in seconds
P_WASH, 1, price per second of wash
P_RINSE, 1, price per second of rinse
P_SPIN, 2, price per second of spin

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
on  in  1  run enable; 0 pauses a running programme
start  in  1  one-cycle pulse; starts a programme in IDLE, acknowledges DONE
bal_load  in  1  loads bal_in into the balance register (IDLE only)
bal_in  in  BAL_W  credit value to load
disp_sel  in  1  0 = remaining seconds, 1 = balance
digits  out  4*NUM_DIGITS  BCD codes, digit 0 in the LSBs; code 4'd11 = blank
st_light  out  8  status lamps
done  out  1  level, high in DONE

Behaviour:
- Reset values: state IDLE, balance 0, tick counter 0, remaining counters 0, done 0, insufficient flag 0, st_light 8'b0000_0001, digits show "0" with leading digits blank.
- Derived constants: COST = T_WASH*P_WASH + T_RINSE*P_RINSE + T_SPIN*P_SPIN (70 with defaults). T_TOT = sum of the three durations. Time counter width = clog2(T_TOT+1).
- States: IDLE, WASH, RINSE, SPIN, DONE.
- IDLE:
  - bal_load: balance <= bal_in, insufficient flag cleared.
  - start with balance >= COST: go to WASH. Phase remaining <= T_WASH, total remaining <= T_TOT, tick counter <= 0.
  - start with balance < COST: stay IDLE, set the sticky insufficient flag, no deduction.
  - bal_load and start in the same cycle: the load wins and start is ignored.
- Run states (WASH/RINSE/SPIN):
  - Tick counter increments each cycle while on=1 and holds while on=0.
  - tick = (counter == TICK_DIV-1) and on. On a tick the counter wraps to 0.
  - On each tick: phase remaining and total remaining decrement by 1; balance decrements by the current phase price.
  - When a tick takes phase remaining from 1 to 0, in the same edge the state advances (WASH->RINSE->SPIN->DONE) and phase remaining loads the next duration.
  - A phase with zero duration is skipped in the same edge.
  - bal_load and start are ignored in run states.
- Underflow: the pre-check guarantees no underflow. The balance subtraction saturates at 0 defensively.
- DONE: done = 1. A start pulse returns the block to IDLE; it does not begin a new programme in that cycle.
- rst mid-programme: returns to IDLE immediately. The balance is cleared and the money is forfeited.
- Latency: the start edge puts the block in the run state. Ticks occur at edges TICK_DIV, 2*TICK_DIV, ... after the start edge. done rises after edge T_TOT*TICK_DIV.
- Display:
  - The selected value (total remaining or balance) is converted to BCD.
  - Values above 10^NUM_DIGITS - 1 saturate to all 9s.
  - Leading zeros are shown as code 11; digit 0 is never blanked.
  - digits is registered, so it is one cycle behind its source.
- st_light bits: [0] IDLE, [1] WASH, [2] RINSE, [3] SPIN, [4] DONE, [5] insufficient flag, [6] paused (run state and on=0), [7] toggles on every tick.

Decomposition:
- Shared package wash_pkg holds:
  - the state enum;
  - the BLANK = 4'd11 code, shared with the scan driver;
  - the st_light bit-index constants.
- One sub-module, bin2bcd: combinational double-dabble, parametrised by input width and NUM_DIGITS, with saturation and leading-zero blanking outputs.

Test Plan:
- Full run (TICK_DIV=4): load bal_in=100, then start. done rises after edge 240 post-start; final balance 30; st_light sequence 0x02 -> 0x04 -> 0x08 -> 0x10.
- Insufficient funds: load 69, then start. State stays IDLE, st_light[5]=1, balance still 69. Load 70 and start: the programme runs and ends with balance 0.
- Pause: deassert on for 10 cycles in RINSE. Remaining and balance are frozen, st_light[6]=1, and done is delayed by exactly 10 cycles.
- Simultaneous bal_load and start in IDLE: the balance is loaded and the state stays IDLE. bal_load during WASH is ignored.
- Reset at tick 35 (RINSE): the next cycle shows IDLE, balance 0, digits = blank,blank,blank,"0", done=0.
- Display: disp_sel=0 right after start shows blank,blank,6,0. disp_sel=1 with balance 5 shows blank,blank,blank,5. Bench override T_WASH=9999 with T_RINSE=T_SPIN=1 shows 9,9,9,9 (saturated).
